// File: rtl/control_fsm_if.sv
// Control bus between the multi-cycle sequencer and the datapath it drives.
// The master side is the FSM, which reads instruction and status and drives
// every enable/select. The slave side is the datapath.
interface control_fsm_if;
    logic [15:0] instr;
    logic        zf;
    logic        mem_ready;

    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic [2:0]  alu_sel;
    logic        alu_src_b;
    logic        mem_req;
    logic        mem_we;
    logic        rf_we;
    logic        wb_sel;
    logic        halted;
    logic        illegal;
    logic [2:0]  state;

    modport master (
        input  instr,
        input  zf,
        input  mem_ready,
        output ir_we,
        output pc_we,
        output pc_src,
        output alu_sel,
        output alu_src_b,
        output mem_req,
        output mem_we,
        output rf_we,
        output wb_sel,
        output halted,
        output illegal,
        output state
    );

    modport slave (
        output instr,
        output zf,
        output mem_ready,
        input  ir_we,
        input  pc_we,
        input  pc_src,
        input  alu_sel,
        input  alu_src_b,
        input  mem_req,
        input  mem_we,
        input  rf_we,
        input  wb_sel,
        input  halted,
        input  illegal,
        input  state
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle control sequencer for a 16-bit processor.
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, plus a sticky HALT.
// All enables are decoded from the current state and the held instruction;
// only the branch PC write (zf) and the MEM exit (mem_ready) look at live
// datapath status. While rst is high every output is forced low.
module control_fsm (
    input  logic          clk,
    input  logic          rst,
    control_fsm_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE = 3'd0,
        C_ADDI  = 3'd1,
        C_LW    = 3'd2,
        C_SW    = 3'd3,
        C_BEQ   = 3'd4,
        C_JMP   = 3'd5,
        C_HALT  = 3'd6,
        C_ILL   = 3'd7
    } op_class_t;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    state_t    state_q;
    state_t    state_d;
    op_class_t op_class;
    logic [3:0] opcode;

    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [2:0] alu_sel;
    logic       alu_src_b;
    logic       mem_req;
    logic       mem_we;
    logic       rf_we;
    logic       wb_sel;
    logic       halted;
    logic       illegal;

    // Map the 4-bit opcode onto an instruction class.
    function automatic op_class_t decode_op(input logic [3:0] op);
        op_class_t cls;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3,
            4'h4, 4'h5, 4'h6: cls = C_RTYPE;
            4'h7:             cls = C_ADDI;
            4'h8:             cls = C_LW;
            4'h9:             cls = C_SW;
            4'hA:             cls = C_BEQ;
            4'hB:             cls = C_JMP;
            4'hF:             cls = C_HALT;
            default:          cls = C_ILL;
        endcase
        return cls;
    endfunction

    // ALU operation chosen in EXEC and held through MEM and WB.
    function automatic logic [2:0] exec_alu_sel(input op_class_t cls,
                                                input logic [3:0] op);
        logic [2:0] sel;
        case (cls)
            C_RTYPE:            sel = op[2:0];
            C_ADDI, C_LW, C_SW: sel = ALU_ADD;
            C_BEQ:              sel = ALU_SUB;
            default:            sel = ALU_ADD;
        endcase
        return sel;
    endfunction

    // Immediate operand for ADDI and address calculation, rs2 otherwise.
    function automatic logic exec_src_b(input op_class_t cls);
        return (cls == C_ADDI) || (cls == C_LW) || (cls == C_SW);
    endfunction

    assign opcode   = bus.instr[15:12];
    assign op_class = decode_op(opcode);

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; outputs forced low while in reset.
    always_comb begin
        state_d   = S_FETCH;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SEQ;
        alu_sel   = ALU_ADD;
        alu_src_b = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                pc_src  = PC_SEQ;
                state_d = S_DECODE;
            end

            S_DECODE: begin
                case (op_class)
                    C_HALT: state_d = S_HALT;
                    C_JMP: begin
                        pc_we   = 1'b1;
                        pc_src  = PC_JUMP;
                        state_d = S_FETCH;
                    end
                    C_ILL: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                alu_sel   = exec_alu_sel(op_class, opcode);
                alu_src_b = exec_src_b(op_class);
                case (op_class)
                    C_RTYPE, C_ADDI: state_d = S_WB;
                    C_LW, C_SW:      state_d = S_MEM;
                    C_BEQ: begin
                        // Branch resolves here: the ALU subtract sets zf.
                        pc_we   = bus.zf;
                        pc_src  = PC_BRANCH;
                        state_d = S_FETCH;
                    end
                    default:         state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                // Address stays on the ALU output until the memory answers.
                alu_sel   = exec_alu_sel(op_class, opcode);
                alu_src_b = exec_src_b(op_class);
                mem_req   = 1'b1;
                mem_we    = (op_class == C_SW);
                if (bus.mem_ready) begin
                    state_d = (op_class == C_LW) ? S_WB : S_FETCH;
                end else begin
                    state_d = S_MEM;
                end
            end

            S_WB: begin
                alu_sel   = exec_alu_sel(op_class, opcode);
                alu_src_b = exec_src_b(op_class);
                rf_we     = 1'b1;
                wb_sel    = (op_class == C_LW);
                state_d   = S_FETCH;
            end

            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end

            default: state_d = S_FETCH;
        endcase

        if (rst) begin
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            pc_src    = PC_SEQ;
            alu_sel   = ALU_ADD;
            alu_src_b = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            rf_we     = 1'b0;
            wb_sel    = 1'b0;
            halted    = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign bus.ir_we     = ir_we;
    assign bus.pc_we     = pc_we;
    assign bus.pc_src    = pc_src;
    assign bus.alu_sel   = alu_sel;
    assign bus.alu_src_b = alu_src_b;
    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.rf_we     = rf_we;
    assign bus.wb_sel    = wb_sel;
    assign bus.halted    = halted;
    assign bus.illegal   = illegal;
    assign bus.state     = state_q;

endmodule
